opsum_writeback: RTL and testbench

//   Downstream consumer of the reducer's final_psum vector. It captures one reduced vector per handshake and packs two 16-bit lanes into each 32-bit GLB word.
//   It then streams those words into the global buffer (GLB) through a req/gnt write port, so the reducer can start its next accumulation immediately.

---
 rtl/opsum_writeback.sv | 134 +++++++++++++
 tb/tb_opsum_writeback.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opsum_writeback.sv
// opsum_writeback
// Captures one reduced psum vector per handshake and streams it into the
// global buffer as 32-bit words, each packing two 16-bit lanes.
// layer_type encoding: 1'b0 = POINTWISE (all LANES lanes), 1'b1 = DEPTHWISE
// (lanes 0..DW_LANES-1 only).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready for a vector; capture on psum_valid
//   S_WRITE | glb_req high, one packed word presented until granted
//   S_DONE  | single-cycle tile_done pulse, then back to S_IDLE
module opsum_writeback #(
    parameter int LANES    = 32,
    parameter int DATA_W   = 16,
    parameter int BUS_W    = 32,
    parameter int ADDR_W   = 32,
    parameter int DW_LANES = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  layer_type,
    input  logic                  psum_valid,
    output logic                  psum_ready,
    input  logic [DATA_W-1:0]     final_psum [LANES-1:0],
    input  logic [ADDR_W-1:0]     opsum_base_addr,
    output logic                  glb_req,
    input  logic                  glb_gnt,
    output logic [ADDR_W-1:0]     glb_addr,
    output logic [BUS_W-1:0]      glb_wdata,
    output logic [BUS_W/8-1:0]    glb_web,
    output logic                  busy,
    output logic                  tile_done
);

    localparam int WORD_W = (LANES > 2) ? $clog2(LANES / 2) : 1;
    localparam int BE_W   = BUS_W / 8;
    localparam int PW_WORDS = (LANES + 1) / 2;
    localparam int DW_WORDS = (DW_LANES + 1) / 2;
    localparam logic [WORD_W-1:0] PW_LAST = WORD_W'(PW_WORDS - 1);
    localparam logic [WORD_W-1:0] DW_LAST = WORD_W'(DW_WORDS - 1);
    localparam logic PW_ODD = (LANES % 2) == 1;
    localparam logic DW_ODD = (DW_LANES % 2) == 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t              state;
    logic [WORD_W-1:0]   word_idx;
    logic [WORD_W-1:0]   last_idx;
    logic                odd_q;
    logic [ADDR_W-1:0]   base_q;
    logic [DATA_W-1:0]   psum_buf [LANES-1:0];

    logic [WORD_W:0]     lane_lo;
    logic [WORD_W:0]     lane_hi;
    logic                half_word;

    // Sequencer: capture in IDLE, walk the words on grants, pulse tile_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            word_idx   <= '0;
            last_idx   <= '0;
            odd_q      <= 1'b0;
            base_q     <= '0;
            for (int i = 0; i < LANES; i++) psum_buf[i] <= '0;
            psum_ready <= 1'b1;
            glb_req    <= 1'b0;
            busy       <= 1'b0;
            tile_done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (psum_valid) begin
                        psum_buf   <= final_psum;
                        base_q     <= opsum_base_addr;
                        last_idx   <= layer_type ? DW_LAST : PW_LAST;
                        odd_q      <= layer_type ? DW_ODD : PW_ODD;
                        word_idx   <= '0;
                        state      <= S_WRITE;
                        psum_ready <= 1'b0;
                        glb_req    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (glb_gnt) begin
                        if (word_idx == last_idx) begin
                            state     <= S_DONE;
                            glb_req   <= 1'b0;
                            tile_done <= 1'b1;
                            word_idx  <= '0;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    tile_done  <= 1'b0;
                    busy       <= 1'b0;
                    psum_ready <= 1'b1;
                    word_idx   <= '0;
                end
                default: begin
                    state      <= S_IDLE;
                    glb_req    <= 1'b0;
                    busy       <= 1'b0;
                    tile_done  <= 1'b0;
                    psum_ready <= 1'b1;
                end
            endcase
        end
    end

    assign lane_lo   = {word_idx, 1'b0};
    assign lane_hi   = {word_idx, 1'b1};
    // With an odd lane count the final word carries only its lower lane.
    assign half_word = odd_q && (word_idx == last_idx);

    // Word presentation: decoded from registered state only, so it stays
    // stable for as long as a request waits for its grant.
    always_comb begin
        glb_addr  = '0;
        glb_wdata = '0;
        glb_web   = '0;
        if (glb_req) begin
            glb_addr                   = base_q + ADDR_W'({word_idx, 2'b00});
            glb_wdata[DATA_W-1:0]      = psum_buf[lane_lo];
            glb_wdata[BUS_W-1:DATA_W]  = half_word ? '0 : psum_buf[lane_hi];
            glb_web                    = half_word ? {{(BE_W/2){1'b0}}, {(BE_W/2){1'b1}}} : '1;
        end
    end

endmodule

// File: tb/tb_opsum_writeback.sv
// tb_opsum_writeback
// Drives psum vectors into two writeback instances (default build and a
// DW_LANES=3 build) and checks every GLB word against a lane-packing model.
module tb_opsum_writeback;

    localparam int LANES  = 32;
    localparam int DATA_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        layer_type = 1'b0;
    logic        psum_valid = 1'b0;
    logic        psum_valid_3 = 1'b0;
    logic        glb_gnt = 1'b0;
    logic [DATA_W-1:0] final_psum [LANES-1:0];
    logic [31:0] base = '0;

    logic        psum_ready, glb_req, busy, tile_done;
    logic [31:0] glb_addr, glb_wdata;
    logic [3:0]  glb_web;
    logic        psum_ready_3, glb_req_3, busy_3, tile_done_3;
    logic [31:0] glb_addr_3, glb_wdata_3;
    logic [3:0]  glb_web_3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    opsum_writeback dut (
        .clk(clk), .rst_n(rst_n), .layer_type(layer_type), .psum_valid(psum_valid),
        .psum_ready(psum_ready), .final_psum(final_psum), .opsum_base_addr(base),
        .glb_req(glb_req), .glb_gnt(glb_gnt), .glb_addr(glb_addr), .glb_wdata(glb_wdata),
        .glb_web(glb_web), .busy(busy), .tile_done(tile_done)
    );

    opsum_writeback #(.DW_LANES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .layer_type(layer_type), .psum_valid(psum_valid_3),
        .psum_ready(psum_ready_3), .final_psum(final_psum), .opsum_base_addr(base),
        .glb_req(glb_req_3), .glb_gnt(glb_gnt), .glb_addr(glb_addr_3), .glb_wdata(glb_wdata_3),
        .glb_web(glb_web_3), .busy(busy_3), .tile_done(tile_done_3)
    );

    task automatic fill_ramp(input int start);
        for (int i = 0; i < LANES; i++) final_psum[i] = 16'(start + i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < LANES; i++) final_psum[i] = 16'($urandom);
    endtask

    // One tile end to end against the model: word k carries lanes 2k/2k+1 of
    // the vector seen at capture, at base+4k; a missing upper lane reads 0
    // and only the low two byte enables are set.
    task automatic run_tile(input bit sel3, input bit lt, input logic [31:0] b,
                            input int stall_word, input int stall_len,
                            input bit scramble, output int done_cyc);
        logic [DATA_W-1:0] e_vec [LANES-1:0];
        int n_lanes, n_words, w, cyc, stalled;
        bit finished;
        logic [31:0] e_addr, e_data, a_addr, a_data;
        logic [3:0]  e_web, a_web;
        logic        a_req, a_done, a_ready, a_busy;

        n_lanes = lt ? (sel3 ? 3 : 10) : LANES;
        n_words = (n_lanes + 1) / 2;
        @(negedge clk);
        a_ready = sel3 ? psum_ready_3 : psum_ready;
        a_done  = sel3 ? tile_done_3 : tile_done;
        a_busy  = sel3 ? busy_3 : busy;
        total++;
        if (a_ready !== 1'b1 || a_done !== 1'b0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_state: ready=%b done=%b busy=%b want 1/0/0", a_ready, a_done, a_busy);
        end
        layer_type = lt;
        base = b;
        glb_gnt = 1'b1;
        if (sel3) psum_valid_3 = 1'b1; else psum_valid = 1'b1;
        e_vec = final_psum;
        w = 0; cyc = 1; stalled = 0; done_cyc = -1; finished = 0;
        @(posedge clk);
        #1;
        if (!scramble) begin
            psum_valid = 1'b0;
            psum_valid_3 = 1'b0;
        end
        while (!finished && cyc < 200) begin
            @(negedge clk);
            cyc++;
            a_req   = sel3 ? glb_req_3 : glb_req;
            a_addr  = sel3 ? glb_addr_3 : glb_addr;
            a_data  = sel3 ? glb_wdata_3 : glb_wdata;
            a_web   = sel3 ? glb_web_3 : glb_web;
            a_done  = sel3 ? tile_done_3 : tile_done;
            a_ready = sel3 ? psum_ready_3 : psum_ready;
            a_busy  = sel3 ? busy_3 : busy;
            if (scramble) begin
                fill_random();
                layer_type = 1'($urandom);
                base = $urandom;
                total++;
                if (a_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL ready_held cyc%0d: ready=%b want 0", cyc, a_ready);
                end
            end
            if (w < n_words) begin
                e_addr = b + 32'(4 * w);
                e_data[15:0]  = e_vec[2*w];
                e_data[31:16] = (2*w + 1 < n_lanes) ? e_vec[2*w+1] : 16'h0;
                e_web = (2*w + 1 < n_lanes) ? 4'hF : 4'h3;
                total++;
                if (a_req !== 1'b1 || a_addr !== e_addr || a_data !== e_data ||
                    a_web !== e_web || a_done !== 1'b0 || a_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL word%0d cyc%0d: req=%b addr=%h data=%h web=%h done=%b busy=%b want 1 %h %h %h 0 1",
                             w, cyc, a_req, a_addr, a_data, a_web, a_done, a_busy, e_addr, e_data, e_web);
                end
                if (w == stall_word && stalled < stall_len) begin
                    glb_gnt = 1'b0;
                    stalled++;
                end else begin
                    glb_gnt = 1'b1;
                    w++;
                end
            end else begin
                total++;
                if (a_done !== 1'b1 || a_req !== 1'b0 || a_busy !== 1'b1 || a_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL done_cycle cyc%0d: done=%b req=%b busy=%b ready=%b want 1 0 1 0",
                             cyc, a_done, a_req, a_busy, a_ready);
                end
                done_cyc = cyc;
                finished = 1;
                psum_valid = 1'b0;
                psum_valid_3 = 1'b0;
                glb_gnt = 1'b0;
            end
        end
        if (!finished) begin
            bad++;
            $display("FAIL timeout: %0d of %0d words after %0d cycles", w, n_words, cyc);
            psum_valid = 1'b0;
            psum_valid_3 = 1'b0;
        end
    endtask

    task automatic check_cycles(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: tile_done at cycle %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++;
        if (psum_ready !== 1'b1 || glb_req !== 1'b0 || busy !== 1'b0 || tile_done !== 1'b0 ||
            glb_addr !== 32'h0 || glb_wdata !== 32'h0 || glb_web !== 4'h0 || psum_ready_3 !== 1'b1) begin
            bad++;
            $display("FAIL reset: ready=%b req=%b busy=%b done=%b addr=%h data=%h web=%h",
                     psum_ready, glb_req, busy, tile_done, glb_addr, glb_wdata, glb_web);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pointwise();
        int dc;
        fill_ramp(1);
        run_tile(0, 0, 32'h1000, -1, 0, 0, dc);
        check_cycles("pointwise_latency", dc, 18);
    endtask

    task automatic test_depthwise();
        int dc;
        fill_ramp(100);
        run_tile(0, 1, 32'h2000, -1, 0, 0, dc);
        check_cycles("depthwise_latency", dc, 7);
    endtask

    task automatic test_backpressure();
        int dc;
        fill_random();
        run_tile(0, 0, 32'h0000_5A00, 4, 3, 0, dc);
        check_cycles("backpressure_latency", dc, 21);
    endtask

    task automatic test_scramble();
        int dc;
        fill_random();
        run_tile(0, 0, 32'h0000_6000, -1, 0, 1, dc);
        check_cycles("scramble_latency", dc, 18);
    endtask

    task automatic test_reset_mid();
        int dc;
        fill_ramp(1);
        @(negedge clk);
        layer_type = 1'b0;
        base = 32'h3000;
        glb_gnt = 1'b1;
        psum_valid = 1'b1;
        @(posedge clk);
        #1 psum_valid = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if (glb_req !== 1'b1 || glb_addr !== 32'h301C) begin
            bad++;
            $display("FAIL mid_word7: req=%b addr=%h want 1 0000301c", glb_req, glb_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (glb_req !== 1'b0 || tile_done !== 1'b0 || psum_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: req=%b done=%b ready=%b busy=%b want 0 0 1 0",
                     glb_req, tile_done, psum_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        glb_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (tile_done !== 1'b0 || glb_req !== 1'b0) begin
                bad++;
                $display("FAIL post_reset%0d: done=%b req=%b want 0 0", i, tile_done, glb_req);
            end
        end
        fill_random();
        run_tile(0, 0, 32'h4000, -1, 0, 0, dc);
        check_cycles("post_reset_latency", dc, 18);
    endtask

    task automatic test_wrap();
        int dc;
        fill_random();
        run_tile(1, 1, 32'hFFFF_FFFC, -1, 0, 0, dc);
        check_cycles("wrap_latency", dc, 4);
        fill_random();
        run_tile(1, 0, 32'hFFFF_FFF0, 2, 1, 0, dc);
        check_cycles("wrap_pw_latency", dc, 19);
    endtask

    task automatic test_back_to_back();
        int dc;
        for (int t = 0; t < 3; t++) begin
            fill_random();
            run_tile(0, 1, 32'h0000_7000 + 32'(t * 20), -1, 0, 0, dc);
            check_cycles("b2b_latency", dc, 7);
        end
    endtask

    task automatic test_random();
        int dc, nw, sw, sl;
        bit lt;
        for (int t = 0; t < 6; t++) begin
            lt = 1'($urandom);
            nw = lt ? 5 : 16;
            sw = $urandom_range(nw - 1, 0);
            sl = $urandom_range(3, 0);
            fill_random();
            run_tile(0, lt, $urandom, sw, sl, 0, dc);
            check_cycles("random_latency", dc, nw + 2 + sl);
        end
    endtask

    initial begin
        test_reset();
        test_pointwise();
        test_depthwise();
        test_backpressure();
        test_scramble();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
